// File: rtl/vc_insert_ctrl_pkg.sv
// Shared types and constants for the victim-cache insert controller.
package vc_pkg;
  localparam int S_OFFSET   = 5;
  localparam int S_LINE     = 8 * (2 ** S_OFFSET);
  localparam int SIZE_OF_VC = 8;
  localparam int PLRU_W     = $clog2(SIZE_OF_VC);
  localparam int TAG_W      = 24;
  localparam int BURST_SIZE = 64;
  localparam int BEATS      = S_LINE / BURST_SIZE;
  localparam int BEAT_W     = $clog2(BEATS);

  typedef enum logic [2:0] {
    IDLE, READ_META, SELECT, RDLINE, WB, INSTALL, ACK
  } vc_state_e;

  function automatic logic [SIZE_OF_VC-1:0] onehot(input logic [PLRU_W-1:0] way);
    onehot      = '0;
    onehot[way] = 1'b1;
  endfunction
endpackage

// File: rtl/vc_insert_ctrl_if.sv
// L1 eviction handshake plus pmem write-back bus; slave is the controller's view.
interface vc_insert_ctrl_if;
  import vc_pkg::*;

  logic              l1_evict_req;
  logic [TAG_W-1:0]  l1_evict_tag;
  logic [S_LINE-1:0] l1_evict_data;
  logic              l1_evict_dirty;
  logic              l1_evict_ack;

  logic                  pmem_write;
  logic [31:0]           pmem_address;
  logic [BURST_SIZE-1:0] pmem_wdata;
  logic                  pmem_resp;

  modport master (
    output l1_evict_req, l1_evict_tag, l1_evict_data, l1_evict_dirty, pmem_resp,
    input  l1_evict_ack, pmem_write, pmem_address, pmem_wdata
  );

  modport slave (
    input  l1_evict_req, l1_evict_tag, l1_evict_data, l1_evict_dirty, pmem_resp,
    output l1_evict_ack, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/vc_wb_serializer.sv
// Holds a victim line and presents it one burst beat at a time, LSB beat first.
module vc_wb_serializer
  import vc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [S_LINE-1:0]     line_in,
  input  logic                  advance,
  output logic [BURST_SIZE-1:0] beat_data,
  output logic                  last
);
  logic [S_LINE-1:0] line_q, line_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  always_comb begin
    line_d = line_q;
    beat_d = beat_q;
    if (load) begin
      line_d = line_in;
      beat_d = '0;
    end else if (advance) begin
      beat_d = beat_q + 1'b1;  // wraps to 0 after the last beat
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
      beat_q <= '0;
    end else begin
      line_q <= line_d;
      beat_q <= beat_d;
    end
  end

  assign beat_data = line_q[int'(beat_q) * BURST_SIZE +: BURST_SIZE];
  assign last      = advance && (beat_q == BEAT_W'(BEATS - 1));
endmodule

// File: rtl/vc_insert_ctrl.sv
// Victim-cache write-side controller: way pick, dirty write-back, install.
// Optional VC_INSERT_STATS_EN adds saturating install / write-back counters.
module vc_insert_ctrl
  import vc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  vc_insert_ctrl_if.slave       bus,
  output logic                  vc_valid_read,
  output logic                  vc_dirty_read,
  output logic                  vc_plru_read,
  output logic                  vc_datastore_read,
  input  logic [SIZE_OF_VC-1:0] vc_valid_dataout,
  input  logic [SIZE_OF_VC-1:0] vc_dirty_dataout,
  input  logic [PLRU_W-1:0]     vc_plru_dataout,
  input  logic [S_LINE-1:0]     vc_vcmem_rdata256,
  output logic [PLRU_W-1:0]     vc_victim_way,
  output logic [TAG_W-1:0]      vc_tag_store_datain,
  output logic [SIZE_OF_VC-1:0] vc_tag_store_ld_mask,
  output logic                  vc_tag_write,
  output logic [S_LINE-1:0]     vc_datastore_datain,
  output logic [SIZE_OF_VC-1:0] vc_datastore_ld_mask,
  output logic [SIZE_OF_VC-1:0] vc_valid_ld,
  output logic [SIZE_OF_VC-1:0] vc_dirty_ld,
  output logic                  vc_valid_datain,
  output logic                  vc_dirty_datain,
  output logic                  vc_plru_ld,
  output logic [PLRU_W-1:0]     vc_plru_datain
`ifdef VC_INSERT_STATS_EN
  ,
  output logic [15:0]           stat_installs,
  output logic [15:0]           stat_writebacks
`endif
);
  vc_state_e state_q, state_d;
  logic [PLRU_W-1:0] way_q, way_d, sel_way;
  logic [SIZE_OF_VC-1:0][TAG_W-1:0] shadow_q, shadow_d;
  logic sel_dirty, wb_last, wb_load, wb_adv;
  logic [BURST_SIZE-1:0] beat_data;

  // Descending scan so the lowest-index invalid way wins; PLRU only when full.
  always_comb begin
    sel_way = vc_plru_dataout;
    for (int i = SIZE_OF_VC - 1; i >= 0; i--)
      if (!vc_valid_dataout[i]) sel_way = PLRU_W'(i);
  end
  assign sel_dirty = vc_valid_dataout[sel_way] & vc_dirty_dataout[sel_way];

  assign wb_load = (state_q == RDLINE);
  assign wb_adv  = (state_q == WB) && bus.pmem_resp;

  vc_wb_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (wb_load),
    .line_in   (vc_vcmem_rdata256),
    .advance   (wb_adv),
    .beat_data (beat_data),
    .last      (wb_last)
  );

  always_comb begin
    state_d              = state_q;
    way_d                = way_q;
    shadow_d             = shadow_q;
    vc_valid_read        = 1'b0;
    vc_dirty_read        = 1'b0;
    vc_plru_read         = 1'b0;
    vc_datastore_read    = 1'b0;
    vc_victim_way        = way_q;
    vc_tag_store_datain  = '0;
    vc_tag_store_ld_mask = '0;
    vc_tag_write         = 1'b0;
    vc_datastore_datain  = '0;
    vc_datastore_ld_mask = '0;
    vc_valid_ld          = '0;
    vc_dirty_ld          = '0;
    vc_valid_datain      = 1'b0;
    vc_dirty_datain      = 1'b0;
    vc_plru_ld           = 1'b0;
    vc_plru_datain       = '0;
    bus.l1_evict_ack     = 1'b0;
    bus.pmem_write       = 1'b0;
    bus.pmem_address     = '0;
    bus.pmem_wdata       = '0;
    unique case (state_q)
      IDLE:      if (bus.l1_evict_req) state_d = READ_META;
      READ_META: begin
        vc_valid_read = 1'b1;
        vc_dirty_read = 1'b1;
        vc_plru_read  = 1'b1;
        state_d       = SELECT;
      end
      SELECT: begin
        vc_victim_way     = sel_way;
        vc_datastore_read = 1'b1;
        way_d             = sel_way;
        state_d           = sel_dirty ? RDLINE : INSTALL;
      end
      RDLINE:    state_d = WB;
      WB: begin
        bus.pmem_write   = 1'b1;
        bus.pmem_address = {shadow_q[way_q], {(32 - TAG_W){1'b0}}};
        bus.pmem_wdata   = beat_data;
        if (wb_last) state_d = INSTALL;
      end
      INSTALL: begin
        vc_tag_store_ld_mask = onehot(way_q);
        vc_datastore_ld_mask = onehot(way_q);
        vc_valid_ld          = onehot(way_q);
        vc_dirty_ld          = onehot(way_q);
        vc_tag_write         = 1'b1;
        vc_tag_store_datain  = bus.l1_evict_tag;
        vc_datastore_datain  = bus.l1_evict_data;
        vc_valid_datain      = 1'b1;
        vc_dirty_datain      = bus.l1_evict_dirty;
        vc_plru_ld           = 1'b1;
        vc_plru_datain       = way_q + 1'b1;
        shadow_d[way_q]      = bus.l1_evict_tag;
        state_d              = ACK;
      end
      ACK: begin
        bus.l1_evict_ack = 1'b1;
        state_d          = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      way_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      way_q    <= way_d;
      shadow_q <= shadow_d;
    end
  end

`ifdef VC_INSERT_STATS_EN
  logic [15:0] inst_q, inst_d, wbk_q, wbk_d;

  // RDLINE always hands over to WB, so counting there counts WB entries.
  always_comb begin
    inst_d = inst_q;
    wbk_d  = wbk_q;
    if (state_q == INSTALL && inst_q != 16'hFFFF) inst_d = inst_q + 16'd1;
    if (state_q == RDLINE  && wbk_q  != 16'hFFFF) wbk_d  = wbk_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q <= '0;
      wbk_q  <= '0;
    end else begin
      inst_q <= inst_d;
      wbk_q  <= wbk_d;
    end
  end

  assign stat_installs   = inst_q;
  assign stat_writebacks = wbk_q;
`endif
endmodule

// File: tb/tb_vc_insert_ctrl.sv
// Random + directed bench for vc_insert_ctrl against a transaction-level model of the VC arrays.
module tb_vc_insert_ctrl;
  import vc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vc_insert_ctrl_if bus();

  logic         vc_valid_read, vc_dirty_read, vc_plru_read, vc_datastore_read;
  logic [7:0]   vc_valid_dataout, vc_dirty_dataout;
  logic [2:0]   vc_plru_dataout;
  logic [255:0] vc_vcmem_rdata256 = '0;
  logic [2:0]   vc_victim_way;
  logic [23:0]  vc_tag_store_datain;
  logic [7:0]   vc_tag_store_ld_mask;
  logic         vc_tag_write;
  logic [255:0] vc_datastore_datain;
  logic [7:0]   vc_datastore_ld_mask, vc_valid_ld, vc_dirty_ld;
  logic         vc_valid_datain, vc_dirty_datain, vc_plru_ld;
  logic [2:0]   vc_plru_datain;
`ifdef VC_INSERT_STATS_EN
  logic [15:0]  stat_installs, stat_writebacks;
`endif

  vc_insert_ctrl dut (
    .clk(clk), .rst(rst), .bus(bus),
    .vc_valid_read(vc_valid_read), .vc_dirty_read(vc_dirty_read),
    .vc_plru_read(vc_plru_read), .vc_datastore_read(vc_datastore_read),
    .vc_valid_dataout(vc_valid_dataout), .vc_dirty_dataout(vc_dirty_dataout),
    .vc_plru_dataout(vc_plru_dataout), .vc_vcmem_rdata256(vc_vcmem_rdata256),
    .vc_victim_way(vc_victim_way), .vc_tag_store_datain(vc_tag_store_datain),
    .vc_tag_store_ld_mask(vc_tag_store_ld_mask), .vc_tag_write(vc_tag_write),
    .vc_datastore_datain(vc_datastore_datain), .vc_datastore_ld_mask(vc_datastore_ld_mask),
    .vc_valid_ld(vc_valid_ld), .vc_dirty_ld(vc_dirty_ld),
    .vc_valid_datain(vc_valid_datain), .vc_dirty_datain(vc_dirty_datain),
    .vc_plru_ld(vc_plru_ld), .vc_plru_datain(vc_plru_datain)
`ifdef VC_INSERT_STATS_EN
    , .stat_installs(stat_installs), .stat_writebacks(stat_writebacks)
`endif
  );

  // Reference view of the VC arrays and the controller's shadow tags.
  logic [7:0]   m_valid = '0, m_dirty = '0;
  logic [2:0]   m_plru = '0;
  logic [23:0]  m_shadow [8];
  logic [255:0] m_data [8];
  int m_inst = 0, m_wbk = 0;

  assign vc_valid_dataout = m_valid;
  assign vc_dirty_dataout = m_dirty;
  assign vc_plru_dataout  = m_plru;
  always @(posedge clk) if (vc_datastore_read) vc_vcmem_rdata256 <= m_data[vc_victim_way];

  int n_chk = 0, n_fail = 0;
  int hold_beat = -1, hold_len = 0, rst_beat = -1;
  bit resp_rand = 1'b0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [2:0] pick_way();
    for (int i = 0; i < 8; i++) if (!m_valid[i]) return 3'(i);
    return m_plru;
  endfunction

  task automatic evict(input logic [23:0] tag, input logic [255:0] data, input logic dbit);
    logic [2:0]   w;
    logic         wb;
    logic [31:0]  addr;
    logic [255:0] line;
    logic [7:0]   oh;
    int k, beat, wcyc, inst, held;
    bit done;
    w    = pick_way();
    wb   = m_valid[w] & m_dirty[w];
    addr = {m_shadow[w], 8'h00};
    line = m_data[w];
    oh   = 8'h01 << w;
    k = 0; beat = 0; wcyc = 0; inst = 0; held = 0; done = 1'b0;
    @(negedge clk);
    bus.l1_evict_req   = 1'b1;
    bus.l1_evict_tag   = tag;
    bus.l1_evict_data  = data;
    bus.l1_evict_dirty = dbit;
    while (!done) begin
      @(negedge clk);
      k++;
      bus.pmem_resp = 1'b0;
      if (k == 1) chk("meta_reads", 256'({vc_valid_read, vc_dirty_read, vc_plru_read}), 256'(3'b111));
      if (k == 2) begin
        chk("data_read", 256'(vc_datastore_read), 256'(1'b1));
        chk("victim_way", 256'(vc_victim_way), 256'(w));
      end
      if (bus.pmem_write) begin
        wcyc++;
        chk("wb_addr", 256'(bus.pmem_address), 256'(addr));
        chk("wb_data", 256'(bus.pmem_wdata), 256'(line[beat*64 +: 64]));
        if (beat == rst_beat) begin
          rst = 1'b1;
          #1;
          chk("rst_pmem_write", 256'(bus.pmem_write), 256'(1'b0));
          for (int c = 0; c < 2; c++) begin
            chk("rst_no_ld", 256'({vc_tag_store_ld_mask, vc_datastore_ld_mask, vc_valid_ld,
                                   vc_dirty_ld, vc_tag_write, vc_plru_ld}), 256'(0));
            chk("rst_no_ack", 256'(bus.l1_evict_ack), 256'(1'b0));
            @(negedge clk);
          end
          rst = 1'b0;
          bus.l1_evict_req = 1'b0;
          for (int i = 0; i < 8; i++) m_shadow[i] = '0;
          m_inst = 0; m_wbk = 0;
          return;
        end else if (beat == hold_beat && held < hold_len) begin
          held++;
        end else if (!resp_rand || $urandom_range(0, 3) != 0) begin
          bus.pmem_resp = 1'b1;
          beat++;
        end
      end
      if ((vc_tag_store_ld_mask | vc_datastore_ld_mask | vc_valid_ld | vc_dirty_ld) != 8'h00 ||
          vc_tag_write || vc_plru_ld) begin
        inst++;
        chk("tag_mask", 256'(vc_tag_store_ld_mask), 256'(oh));
        chk("data_mask", 256'(vc_datastore_ld_mask), 256'(oh));
        chk("valid_ld", 256'(vc_valid_ld), 256'(oh));
        chk("dirty_ld", 256'(vc_dirty_ld), 256'(oh));
        chk("ctl_bits", 256'({vc_tag_write, vc_valid_datain, vc_dirty_datain, vc_plru_ld}),
            256'({1'b1, 1'b1, dbit, 1'b1}));
        chk("tag_din", 256'(vc_tag_store_datain), 256'(tag));
        chk("data_din", vc_datastore_datain, data);
        chk("plru_din", 256'(vc_plru_datain), 256'(3'(w + 3'd1)));
        m_valid[w] = 1'b1;
        m_dirty[w] = dbit;
        m_plru     = w + 3'd1;
        m_shadow[w] = tag;
        m_data[w]   = data;
        m_inst++;
        if (wb) m_wbk++;
      end
      if (bus.l1_evict_ack) begin
        chk("ack_latency", 256'(k), 256'(wb ? 5 + wcyc : 4));
        chk("wb_beats", 256'(beat), 256'(wb ? 4 : 0));
        chk("installs", 256'(inst), 256'(1));
        bus.l1_evict_req = 1'b0;
        done = 1'b1;
      end else if (k > 300) begin
        chk("timeout_cycles", 256'(k), 256'(0));
        bus.l1_evict_req = 1'b0;
        done = 1'b1;
      end
    end
  endtask

  initial begin
    bus.l1_evict_req = 1'b0; bus.l1_evict_tag = '0; bus.l1_evict_data = '0;
    bus.l1_evict_dirty = 1'b0; bus.pmem_resp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_shadow[i] = '0;
      m_data[i]   = rand_line();
    end
    repeat (2) @(negedge clk);
    chk("rst_outs", 256'({bus.pmem_write, bus.l1_evict_ack, vc_valid_read, vc_datastore_read,
                          vc_tag_write, vc_plru_ld, vc_victim_way}), 256'(0));
    chk("rst_masks", 256'({vc_tag_store_ld_mask, vc_datastore_ld_mask, vc_valid_ld, vc_dirty_ld}), 256'(0));
    chk("rst_addr", 256'(bus.pmem_address), 256'(0));
    rst = 1'b0;

    // Empty VC, clean line lands in way 0
    evict(24'h00ABCD, rand_line(), 1'b0);

    // Plant tag 0x123456 in way 5, then force it out dirty with beat 2 held off
    m_valid = 8'hDF; m_plru = 3'd0;
    evict(24'h123456, rand_line(), 1'b0);
    m_valid = 8'hFF; m_dirty = 8'h20; m_plru = 3'd5;
    chk("shadow5", 256'(m_shadow[5]), 256'(24'h123456));
    hold_beat = 2; hold_len = 10;
    evict(24'h0F0F0F, rand_line(), 1'b1);
    hold_beat = -1;

    m_valid = 8'hFF; m_dirty = 8'h00; m_plru = 3'd7;
    evict(24'hBEEF01, rand_line(), 1'b0);
    m_valid = 8'hF7; m_plru = 3'd1;
    evict(24'hBEEF02, rand_line(), 1'b1);

    // Abort mid write-back, then the L1 re-issues the same eviction
    m_valid = 8'hFF; m_dirty = 8'hFF; m_plru = 3'd2;
    rst_beat = 1;
    evict(24'hC0FFEE, rand_line(), 1'b1);
    rst_beat = -1;
`ifdef VC_INSERT_STATS_EN
    chk("stat_inst_rst", 256'(stat_installs), 256'(0));
    chk("stat_wbk_rst", 256'(stat_writebacks), 256'(0));
`endif
    evict(24'hC0FFEE, rand_line(), 1'b1);

    resp_rand = 1'b1;
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0: m_valid = 8'($urandom);
        1: m_valid = 8'hFF;
        default: ;
      endcase
      m_dirty = 8'($urandom);
      m_plru  = 3'($urandom);
      evict(24'($urandom), rand_line(), 1'($urandom));
    end

`ifdef VC_INSERT_STATS_EN
    @(negedge clk);
    chk("stat_installs", 256'(stat_installs), 256'(m_inst));
    chk("stat_writebacks", 256'(stat_writebacks), 256'(m_wbk));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
